// File: rtl/icache_refill_ctrl_pkg.sv
// Shared AHB and refill definitions for the instruction-cache line refill controller.
package icache_refill_ctrl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } burst_types_e;

  localparam int         LINE_WORDS = 4;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Refill FSM encoding, kept as plain constants for legacy tooling.
  typedef logic [2:0] refill_state_t;
  localparam refill_state_t ST_IDLE = 3'd0;
  localparam refill_state_t ST_NSEQ = 3'd1;
  localparam refill_state_t ST_SEQ  = 3'd2;
  localparam refill_state_t ST_LAST = 3'd3;
  localparam refill_state_t ST_ERR  = 3'd4;

endpackage

// File: rtl/icache_refill_ctrl_wrap4_addr_gen.sv
// Word address inside a 16-byte line; the 2-bit word index wraps so a burst never leaves the line.
module wrap4_addr_gen
  import icache_refill_ctrl_pkg::*;
(
  input  logic [31:4] base,
  input  logic [1:0]  start,
  input  logic [1:0]  beat,
  output logic [31:0] haddr
);

  logic [1:0] word;

  assign word  = start + beat;
  assign haddr = {base, word, 2'b00};

endmodule

// File: rtl/icache_refill_ctrl.sv
// AHB master that refills one 4-word I-cache line, critical word first (WRAP4) or from line base (INCR4).
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter bit CRIT_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        miss_valid,
  input  logic [31:0] miss_addr,
  output logic        miss_ready,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic [2:0]  hburst,
  output logic [2:0]  hsize,
  output logic        hwrite,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp,
  output logic        fill_we,
  output logic [1:0]  fill_idx,
  output logic [31:0] fill_data,
  output logic        crit_valid,
  output logic        fill_done,
  output logic        fill_err
);

  localparam burst_types_e BURST_KIND = CRIT_FIRST ? BURST_WRAP4 : BURST_INCR4;

  refill_state_t state_q, state_d;
  logic [31:4]   base_q, base_d;
  logic [1:0]    start_q, start_d;
  logic [1:0]    issued_q, issued_d;
  logic [31:0]   gen_addr;
  logic          dphase;
  logic          err_now;
  htrans_t       htrans_e;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^miss_addr[1:0];

  wrap4_addr_gen u_addr_gen (
    .base  (base_q),
    .start (start_q),
    .beat  (issued_q),
    .haddr (gen_addr)
  );

  // A data phase is outstanding whenever an address has been accepted but its beat not yet taken.
  assign dphase  = (state_q == ST_SEQ) || (state_q == ST_LAST);
  assign err_now = dphase && (hresp == HRESP_ERROR);

  assign htrans    = htrans_e;
  assign hsize     = HSIZE_WORD;
  assign hwrite    = 1'b0;
  assign fill_data = hrdata;
  // issued_q runs one ahead of the beat in its data phase; in LAST it has wrapped to 0.
  assign fill_idx  = start_q + issued_q - 2'd1;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    start_d    = start_q;
    issued_d   = issued_q;
    miss_ready = 1'b0;
    htrans_e   = HTRANS_IDLE;
    haddr      = 32'd0;
    hburst     = BURST_SINGLE;
    fill_we    = 1'b0;
    crit_valid = 1'b0;
    fill_done  = 1'b0;
    fill_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          base_d   = miss_addr[31:4];
          start_d  = CRIT_FIRST ? miss_addr[3:2] : 2'd0;
          issued_d = 2'd0;
          state_d  = ST_NSEQ;
        end
      end
      ST_NSEQ: begin
        htrans_e = HTRANS_NONSEQ;
        haddr    = gen_addr;
        hburst   = BURST_KIND;
        if (hready) begin
          issued_d = 2'd1;
          state_d  = ST_SEQ;
        end
      end
      ST_SEQ, ST_LAST: begin
        hburst = BURST_KIND;
        if (err_now) begin
          // Drop the pending address at once; a one-cycle error response finishes here.
          if (hready) begin
            fill_err = 1'b1;
            issued_d = 2'd0;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_ERR;
          end
        end else if (state_q == ST_SEQ) begin
          htrans_e = HTRANS_SEQ;
          haddr    = gen_addr;
          if (hready) begin
            fill_we    = 1'b1;
            crit_valid = (issued_q == 2'd1);
            issued_d   = issued_q + 2'd1;
            if (issued_q == 2'(LINE_WORDS - 1)) state_d = ST_LAST;
          end
        end else if (hready) begin
          fill_we   = 1'b1;
          fill_done = 1'b1;
          issued_d  = 2'd0;
          state_d   = ST_IDLE;
        end
      end
      ST_ERR: begin
        hburst = BURST_KIND;
        if (hready) begin
          fill_err = 1'b1;
          issued_d = 2'd0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      start_q  <= 2'd0;
      issued_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      start_q  <= start_d;
      issued_q <= issued_d;
    end
  end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameter CRIT_FIRST, default 1: 1 = WRAP4 burst starting at missed word; 0 = INCR4 burst starting at line base.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port miss_valid  input  1  cache miss request.
REQ-005 SHALL have port miss_addr  input  32  missing fetch address.
REQ-006 SHALL have port miss_ready  output  1  controller idle; request accepted when miss_valid&&miss_ready.
REQ-007 SHALL have ports haddr output 32, htrans output 2, hburst output 3, hsize output 3, hwrite output 1  AHB master address-phase signals.
REQ-008 SHALL have ports hrdata input 32, hready input 1, hresp input 1 (0 OKAY, 1 ERROR)  AHB data-phase signals.
REQ-009 SHALL have ports fill_we output 1, fill_idx output 2, fill_data output 32  line-buffer word write.
REQ-010 SHALL have ports crit_valid output 1, fill_done output 1, fill_err output 1  one-cycle pulses.

Function
REQ-011 SHALL implement states IDLE, NSEQ, SEQ, LAST, ERR; line = 16 bytes = 4 words.
REQ-012 IDLE: miss_ready=1, htrans=IDLE; on accept, register base=miss_addr&0xFFFF_FFF0, start=CRIT_FIRST ? miss_addr[3:2] : 0; go NSEQ.
REQ-013 NSEQ: htrans=NONSEQ, haddr=base|{start,2'b00}; on hready go SEQ with issued=1.
REQ-014 SEQ: htrans=SEQ, haddr=base|{(start+issued) mod 4,2'b00} (2-bit wrap, never crosses 16-byte boundary); each hready captures one data beat and increments issued; after 4th address accepted go LAST.
REQ-015 LAST: htrans=IDLE; on hready capture 4th beat, pulse fill_done same cycle as final fill_we, go IDLE.
REQ-016 Data beat k captured on cycle k+1 address acceptance: fill_we=hready&&data-phase-active&&!hresp, fill_idx=(start+k) mod 4, fill_data=hrdata.
REQ-017 crit_valid SHALL pulse with the first fill_we of each burst only.
REQ-018 hready=0: haddr/htrans/state/counters held; no fill_we.
REQ-019 hwrite=0, hsize=3'b010 always; hburst=3'b010 (WRAP4) when CRIT_FIRST=1 else 3'b011 (INCR4); hburst=0 in IDLE.
REQ-020 hresp=1 in any data phase: htrans SHALL be IDLE combinationally that cycle; go ERR; no further fill_we for this burst.
REQ-021 ERR: htrans=IDLE; on hready&&hresp pulse fill_err, go IDLE; fill_done never asserted for that burst.
REQ-022 miss_valid while busy SHALL be ignored (miss_ready=0); miss_addr sampled only at accept.
REQ-023 Back-to-back misses: next miss accepted earliest cycle after fill_done/fill_err.

Reset
REQ-024 rstn low SHALL force IDLE, miss_ready=1, htrans=IDLE, hburst=0, haddr=0, all pulses 0, counters 0.
REQ-025 Reset mid-burst SHALL discard partial fill with no fill_done or fill_err.

Structure
REQ-026 HTRANS_T (IDLE/BUSY/NONSEQ/SEQ), HRESP codes, the existing BURST_TYPES enum, LINE_WORDS=4 and refill state enum SHALL live in the shared interface package.
REQ-027 Wrap address generation SHALL be sub-module wrap4_addr_gen (base, start, beat -> haddr).

Verification
REQ-028 CRIT_FIRST=1, miss_addr=0x1008, hready=1 -> haddr 0x1008,0x100C,0x1000,0x1004; fill_idx 2,3,0,1; crit_valid with idx 2; fill_done 5 cycles after accept.
REQ-029 CRIT_FIRST=0, miss_addr=0x200C -> hburst=INCR4, haddr 0x2000..0x200C, fill_idx 0..3.
REQ-030 hready=0 for 2 cycles on beat 2 -> haddr/htrans held, exactly 4 fill_we total, idx order unchanged.
REQ-031 hresp=1 on beat 1 (2-cycle ERROR) -> htrans=IDLE immediately, fill_err one pulse, no fill_done, miss_ready=1 next cycle.
REQ-032 rstn low during SEQ, then new miss 0x3004 -> clean IDLE, no stale pulses, new burst 0x3004,0x3008,0x300C,0x3000.
